// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and defaults for the UART TX buffer stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int C_DATA_WIDTH = 8;
    localparam int C_BUSY_TO    = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : Register array, synchronous write port, asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    // Contents are deliberately left unreset; occupancy tracking makes stale data invisible.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO feeding the UART TX, one-cycle issue strobe gated
//                by TX_BUSY with a bounded wait for the TX to acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH   = C_DATA_WIDTH,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int BUSY_TO = C_BUSY_TO
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              FLUSH,
    input  logic [WIDTH-1:0]  WR_DATA,
    input  logic              WR_EN,
    output logic              FULL,
    output logic              EMPTY,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW,
    output logic [WIDTH-1:0]  TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_BUSY
);

    localparam int              C_TMR_W    = $clog2(BUSY_TO + 1);
    localparam logic [ADDR_W:0] C_FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;
    logic [WIDTH-1:0]   r_tx_data;
    logic               r_tx_valid;
    logic [C_TMR_W-1:0] r_timer;
    tx_state_t          r_state;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_rd_data;

    // Flags come from the registered count only, so FULL is the pre-edge value.
    assign w_full = (r_count == C_FULL_CNT);
    assign w_push = WR_EN && !w_full && !FLUSH;
    assign w_pop  = (r_state == ST_IDLE) && (r_count != '0) && !TX_BUSY && !FLUSH;

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (CLK),
        .i_wr_en   (w_push && Reset),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (WR_DATA),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_timer    <= '0;
            r_state    <= ST_IDLE;
        end else if (FLUSH) begin
            // TX_DATA is kept: a frame already handed to the TX is not recalled.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_valid <= 1'b0;
            r_timer    <= '0;
            r_state    <= ST_IDLE;
        end else begin
            r_tx_valid <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (WR_EN && w_full) begin
                r_overflow <= 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_rd_data;
                        r_tx_valid <= 1'b1;
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                        r_timer    <= C_TMR_W'(BUSY_TO);
                        r_state    <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    // A TX that never acknowledges still consumes the word.
                    if (TX_BUSY) begin
                        r_state <= ST_WAIT_DONE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        if (r_timer <= C_TMR_W'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (!TX_BUSY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign FULL     = w_full;
    assign EMPTY    = (r_count == '0);
    assign COUNT    = r_count;
    assign OVERFLOW = r_overflow;
    assign TX_DATA  = r_tx_data;
    assign TX_VALID = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed and randomized bench with a queue-based reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH   = 8;
    localparam int BUSY_TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       tx_busy = 1'b0;
    logic       full, empty, overflow, tx_valid;
    logic [3:0] count;
    logic [7:0] tx_data;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .WIDTH   (8),
        .DEPTH   (DEPTH),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .CLK      (clk),
        .Reset    (rst_n),
        .FLUSH    (flush),
        .WR_DATA  (wr_data),
        .WR_EN    (wr_en),
        .FULL     (full),
        .EMPTY    (empty),
        .COUNT    (count),
        .OVERFLOW (overflow),
        .TX_DATA  (tx_data),
        .TX_VALID (tx_valid),
        .TX_BUSY  (tx_busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of pending words plus the link status towards the TX.
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_txd = 8'h00;
    logic       m_txv = 1'b0;
    int         m_link = 0;     // 0 free, 1 awaiting TX ack, 2 TX sending
    int         m_left = 0;     // cycles of ack grace remaining

    always @(posedge clk) begin
        bit was_full, may_issue;
        if (!rst_n) begin
            m_q.delete(); m_ovf = 0; m_txd = 0; m_txv = 0; m_link = 0;
        end else if (flush) begin
            m_q.delete(); m_ovf = 0; m_txv = 0; m_link = 0;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            may_issue = (m_link == 0) && (m_q.size() > 0) && !tx_busy;
            m_txv = 0;
            if (may_issue) begin
                m_txd = m_q.pop_front();
                m_txv = 1;
                m_link = 1;
                m_left = BUSY_TO;
            end else if (m_link == 1) begin
                if (tx_busy) m_link = 2;
                else begin
                    m_left--;
                    if (m_left == 0) m_link = 0;
                end
            end else if (m_link == 2 && !tx_busy) begin
                m_link = 0;
            end
            if (wr_en) begin
                if (was_full) m_ovf = 1;
                else m_q.push_back(wr_data);
            end
        end
    end

    bit         chk_en = 0;
    bit         prev_valid = 0;
    logic [7:0] issued[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("COUNT", int'(count), m_q.size());
            check("FULL", int'(full), int'(m_q.size() == DEPTH));
            check("EMPTY", int'(empty), int'(m_q.size() == 0));
            check("OVERFLOW", int'(overflow), int'(m_ovf));
            check("TX_VALID", int'(tx_valid), int'(m_txv));
            check("TX_DATA", int'(tx_data), int'(m_txd));
            check("TX_VALID_back_to_back", int'(tx_valid && prev_valid), 0);
            prev_valid = tx_valid;
            if (tx_valid) issued.push_back(tx_data);
        end
    end

    // TX emulation: raise busy two cycles after an issue, hold it for ten.
    bit resp_on = 0;
    int resp_delay = 0;
    int resp_hold = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (resp_on) begin
            if (tx_valid) resp_delay = 2;
            else if (resp_delay > 0) begin
                resp_delay--;
                if (resp_delay == 0) begin tx_busy = 1; resp_hold = 10; end
            end else if (resp_hold > 0) begin
                resp_hold--;
                if (resp_hold == 0) tx_busy = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 0; flush = 0; wr_en = 0; tx_busy = 0; resp_on = 0;
        resp_delay = 0; resp_hold = 0;
        tick(); tick();
        rst_n = 1;
        issued.delete();
    endtask

    task automatic write(input logic [7:0] d);
        wr_en = 1; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    initial begin
        int first_at, gap;
        do_reset();
        chk_en = 1;
        check("reset_COUNT", int'(count), 0);
        check("reset_EMPTY", int'(empty), 1);
        check("reset_TX_DATA", int'(tx_data), 0);

        // Single word, latency of one edge after acceptance.
        write(8'hA5);
        check("t1_count_after_write", int'(count), 1);
        check("t1_no_valid_yet", int'(tx_valid), 0);
        tick();
        check("t1_valid", int'(tx_valid), 1);
        check("t1_data", int'(tx_data), 8'hA5);
        check("t1_count_after_issue", int'(count), 0);
        tick();
        check("t1_valid_one_cycle", int'(tx_valid), 0);
        check("t1_empty", int'(empty), 1);

        // Three words through an acknowledging TX.
        do_reset();
        resp_on = 1;
        write(8'h11); write(8'h22); write(8'h33);
        for (int i = 0; i < 60; i++) tick();
        check("t2_issued_n", issued.size(), 3);
        if (issued.size() == 3) begin
            check("t2_w0", int'(issued[0]), 8'h11);
            check("t2_w1", int'(issued[1]), 8'h22);
            check("t2_w2", int'(issued[2]), 8'h33);
        end

        // Overfill while the TX is busy.
        do_reset();
        tx_busy = 1;
        for (int i = 1; i <= 9; i++) write(8'h30 + 8'(i));
        check("t3_full", int'(full), 1);
        check("t3_count", int'(count), 8);
        check("t3_overflow", int'(overflow), 1);
        tx_busy = 0;
        for (int i = 0; i < 60; i++) tick();
        check("t3_issued_n", issued.size(), 8);
        if (issued.size() == 8) begin
            check("t3_first", int'(issued[0]), 8'h31);
            check("t3_last", int'(issued[7]), 8'h38);
        end

        // Write while full in the same cycle as a pop.
        do_reset();
        tx_busy = 1;
        for (int i = 0; i < 8; i++) write(8'h40 + 8'(i));
        check("t4_full_pre", int'(full), 1);
        check("t4_ovf_pre", int'(overflow), 0);
        tx_busy = 0;
        write(8'hEE);
        check("t4_valid", int'(tx_valid), 1);
        check("t4_data", int'(tx_data), 8'h40);
        check("t4_count", int'(count), 7);
        check("t4_overflow", int'(overflow), 1);

        // TX never acknowledges: bounded wait, no repeats.
        do_reset();
        write(8'h01); write(8'h02);
        first_at = -1; gap = -1;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) begin
                if (first_at < 0) first_at = i;
                else if (gap < 0) gap = i - first_at;
            end
            tick();
        end
        check("t5_issued_n", issued.size(), 2);
        check("t5_gap", gap, 5);
        if (issued.size() == 2) begin
            check("t5_w0", int'(issued[0]), 8'h01);
            check("t5_w1", int'(issued[1]), 8'h02);
        end

        // Flush with a write in the same cycle.
        do_reset();
        tx_busy = 1;
        for (int i = 0; i < 5; i++) write(8'h50 + 8'(i));
        check("t6_count_pre", int'(count), 5);
        flush = 1; wr_en = 1; wr_data = 8'h99;
        tick();
        flush = 0; wr_en = 0;
        check("t6_count", int'(count), 0);
        check("t6_empty", int'(empty), 1);
        check("t6_overflow", int'(overflow), 0);
        check("t6_no_valid", int'(tx_valid), 0);
        tx_busy = 0;
        tick();
        write(8'h7E);
        tick();
        check("t6_valid", int'(tx_valid), 1);
        check("t6_data", int'(tx_data), 8'h7E);

        // Randomized traffic against the reference.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
            flush   = ($urandom_range(0, 63) == 0);
            rst_n   = ($urandom_range(0, 255) != 0);
            resp_on = ((i / 100) % 2) == 1;
            if (!resp_on) tx_busy = ($urandom_range(0, 2) == 0);
            tick();
        end
        wr_en = 0; flush = 0; rst_n = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
